// File: rtl/ccl_pkg.sv
// rtl/ccl_pkg.sv - shared types and constants for the stream labeler
// CCL_CONN8_EN selects 8-connectivity (4 neighbours, 3-entry merge queue).
package ccl_pkg;

  typedef enum logic {IDLE, MERGE} ccl_state_e;

  localparam int DEF_LABEL_WIDTH = 6;
  localparam int DEF_IMG_WIDTH   = 640;

`ifdef CCL_CONN8_EN
  localparam int CCL_NCONN = 4;
`else
  localparam int CCL_NCONN = 2;
`endif
  localparam int CCL_MQ_DEPTH = CCL_NCONN - 1;

  function automatic int unsigned MAX_LABEL(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ccl_line_buffer.sv
// rtl/ccl_line_buffer.sv - previous-row label store, one shift per accepted pixel
// CCL_CONN8_EN adds the top-left and top-right taps.
module ccl_line_buffer #(
  parameter int LABEL_WIDTH = 6,
  parameter int IMG_WIDTH   = 640
) (
  input  logic                   clk,
  input  logic                   shift_en_i,
  input  logic [LABEL_WIDTH-1:0] din_i,
  output logic [LABEL_WIDTH-1:0] t_o
`ifdef CCL_CONN8_EN
  ,
  output logic [LABEL_WIDTH-1:0] tl_o,
  output logic [LABEL_WIDTH-1:0] tr_o
`endif
);

  // Entry i holds the label written i+1 accepts ago; the oldest entry sits above x.
  logic [LABEL_WIDTH-1:0] line_q [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      line_q[0] <= din_i;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign t_o = line_q[IMG_WIDTH-1];

`ifdef CCL_CONN8_EN
  logic [LABEL_WIDTH-1:0] tl_q;

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      tl_q <= line_q[IMG_WIDTH-1];
    end
  end

  assign tl_o = tl_q;
  assign tr_o = line_q[IMG_WIDTH-2];
`endif

endmodule

// File: rtl/ccl_stream_labeler.sv
// rtl/ccl_stream_labeler.sv - streaming first-pass connected-component labeler
// Default build is 4-connected; define CCL_CONN8_EN for 8-connectivity.
module ccl_stream_labeler
  import ccl_pkg::*;
#(
  parameter int LABEL_WIDTH = DEF_LABEL_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic                   in_motion,
  output logic                   label_valid,
  output logic [LABEL_WIDTH-1:0] label,
  output logic                   new_label_valid,
  output logic [LABEL_WIDTH-1:0] new_label_value,
  output logic                   merge_valid,
  input  logic                   merge_ready,
  output logic [LABEL_WIDTH-1:0] merge_a,
  output logic [LABEL_WIDTH-1:0] merge_b,
  output logic                   label_overflow
);

  localparam int XW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CW  = (CCL_MQ_DEPTH > 1) ? 2 : 1;
  localparam int NLW = LABEL_WIDTH + 1;
  localparam logic [XW-1:0]  XLAST = XW'(IMG_WIDTH - 1);
  localparam logic [NLW-1:0] MAXL  = NLW'(MAX_LABEL(LABEL_WIDTH));

  ccl_state_e             state_q, state_d;
  logic [XW-1:0]          x_q, x_d, x_cur;
  logic                   first_row_q, first_row_d, first_eff;
  logic [NLW-1:0]         next_label_q, next_label_d, nl_eff;
  logic                   overflow_q, overflow_d, ovf_eff;
  logic [LABEL_WIDTH-1:0] left_q, left_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;
  logic                   label_valid_q, label_valid_d;
  logic                   new_valid_q, new_valid_d;
  logic [LABEL_WIDTH-1:0] new_value_q, new_value_d;
  logic [LABEL_WIDTH-1:0] merge_a_q, merge_a_d;
  logic [LABEL_WIDTH-1:0] mq_q [CCL_MQ_DEPTH];
  logic [LABEL_WIDTH-1:0] mq_d [CCL_MQ_DEPTH];
  logic [LABEL_WIDTH-1:0] mq_new [CCL_MQ_DEPTH];
  logic [CW-1:0]          mcnt_q, mcnt_d, k;
  logic [LABEL_WIDTH-1:0] nb [CCL_NCONN];
  logic [LABEL_WIDTH-1:0] m, prev, cand, t_tap, pix_label;
  logic                   accept;

  assign accept    = in_valid && (state_q == IDLE);
  assign x_cur     = in_sof ? '0 : x_q;
  assign first_eff = in_sof | first_row_q;
  assign nl_eff    = in_sof ? NLW'(1) : next_label_q;
  assign ovf_eff   = in_sof ? 1'b0 : overflow_q;

`ifdef CCL_CONN8_EN
  logic [LABEL_WIDTH-1:0] tl_tap, tr_tap;

  ccl_line_buffer #(.LABEL_WIDTH(LABEL_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_line (
    .clk(clk), .shift_en_i(accept), .din_i(pix_label),
    .t_o(t_tap), .tl_o(tl_tap), .tr_o(tr_tap)
  );

  assign nb[2] = (first_eff || x_cur == '0)   ? '0 : tl_tap;
  assign nb[3] = (first_eff || x_cur == XLAST) ? '0 : tr_tap;
`else
  ccl_line_buffer #(.LABEL_WIDTH(LABEL_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_line (
    .clk(clk), .shift_en_i(accept), .din_i(pix_label), .t_o(t_tap)
  );
`endif

  assign nb[0] = (x_cur == '0) ? '0 : left_q;
  assign nb[1] = first_eff ? '0 : t_tap;

  // Minimum non-zero neighbour, then the remaining distinct values in ascending order.
  always_comb begin
    m = '0;
    for (int i = 0; i < CCL_NCONN; i++) begin
      if (nb[i] != '0 && (m == '0 || nb[i] < m)) m = nb[i];
    end
    k    = '0;
    prev = m;
    cand = '0;
    for (int j = 0; j < CCL_MQ_DEPTH; j++) begin
      cand = '0;
      for (int i = 0; i < CCL_NCONN; i++) begin
        if (nb[i] > prev && (cand == '0 || nb[i] < cand)) cand = nb[i];
      end
      mq_new[j] = cand;
      if (cand != '0) begin
        k    = k + CW'(1);
        prev = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    first_row_d   = first_row_q;
    next_label_d  = next_label_q;
    overflow_d    = overflow_q;
    left_d        = left_q;
    label_d       = label_q;
    label_valid_d = 1'b0;
    new_valid_d   = 1'b0;
    new_value_d   = new_value_q;
    merge_a_d     = merge_a_q;
    mq_d          = mq_q;
    mcnt_d        = mcnt_q;
    pix_label     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          next_label_d = nl_eff;
          overflow_d   = ovf_eff;
          if (in_motion) begin
            if (m != '0) begin
              pix_label = m;
            end else if (nl_eff <= MAXL) begin
              pix_label    = nl_eff[LABEL_WIDTH-1:0];
              next_label_d = nl_eff + NLW'(1);
              new_valid_d  = 1'b1;
              new_value_d  = nl_eff[LABEL_WIDTH-1:0];
            end else begin
              pix_label  = MAXL[LABEL_WIDTH-1:0];
              overflow_d = 1'b1;
            end
          end
          x_d           = (x_cur == XLAST) ? '0 : x_cur + XW'(1);
          first_row_d   = (x_cur == XLAST) ? 1'b0 : first_eff;
          left_d        = pix_label;
          label_d       = pix_label;
          label_valid_d = 1'b1;
          if (in_motion && k != '0) begin
            state_d   = MERGE;
            merge_a_d = m;
            mq_d      = mq_new;
            mcnt_d    = k;
          end
        end
      end
      MERGE: begin
        if (merge_ready) begin
          for (int j = 0; j < CCL_MQ_DEPTH - 1; j++) mq_d[j] = mq_q[j+1];
          mq_d[CCL_MQ_DEPTH-1] = '0;
          mcnt_d = mcnt_q - CW'(1);
          if (mcnt_q == CW'(1)) begin
            state_d   = IDLE;
            merge_a_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      first_row_q   <= 1'b1;
      next_label_q  <= NLW'(1);
      overflow_q    <= 1'b0;
      left_q        <= '0;
      label_q       <= '0;
      label_valid_q <= 1'b0;
      new_valid_q   <= 1'b0;
      new_value_q   <= '0;
      merge_a_q     <= '0;
      mq_q          <= '{default: '0};
      mcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      first_row_q   <= first_row_d;
      next_label_q  <= next_label_d;
      overflow_q    <= overflow_d;
      left_q        <= left_d;
      label_q       <= label_d;
      label_valid_q <= label_valid_d;
      new_valid_q   <= new_valid_d;
      new_value_q   <= new_value_d;
      merge_a_q     <= merge_a_d;
      mq_q          <= mq_d;
      mcnt_q        <= mcnt_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign merge_valid     = (state_q == MERGE);
  assign label_valid     = label_valid_q;
  assign label           = label_q;
  assign new_label_valid = new_valid_q;
  assign new_label_value = new_value_q;
  assign merge_a         = merge_a_q;
  assign merge_b         = mq_q[0];
  assign label_overflow  = overflow_q;

endmodule
